bram_rr_arbiter: RTL and testbench
==================================

// Module: bram_rr_arbiter
// PURPOSE
//  Shares one single-port synchronous block RAM (1-cycle read latency, read-first) among NUM_REQ requesters.
//  - Round-robin arbitration, one access per cycle.
//  - Optional locked bursts of up to BURST_MAX beats.
//  - Read data is returned one cycle after acceptance, tagged to the winning requester.
//  - Sits between client engines and a block_ram_1d instance; owns the RAM port exclusively.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..16)
//  ADDR_WIDTH  8   RAM address width (depth 2^ADDR_WIDTH)
//  DATA_WIDTH  32  RAM data width
//  BURST_MAX   16  max consecutive grants to one locked requester (1..256)
// PORTS
//  clk        in   1                     clock; all logic on posedge
//  rst        in   1                     synchronous reset, active-high
//  req_valid  in   NUM_REQ               per-requester access request
//  req_we     in   NUM_REQ               1=write, 0=read
//  req_lock   in   NUM_REQ               hold grant for next beat (burst)
//  req_addr   in   NUM_REQ x ADDR_WIDTH  packed per-requester address
//  req_wdata  in   NUM_REQ x DATA_WIDTH  packed per-requester write data
//  req_ready  out  NUM_REQ               one-hot grant; access accepted when valid&ready
//  rsp_valid  out  NUM_REQ               one-hot read-data strobe, 1 cycle after read accept
//  rsp_rdata  out  DATA_WIDTH            read data (ram_rdata passthrough); valid only with rsp_valid
//  ram_we     out  1                     RAM write enable
//  ram_addr   out  ADDR_WIDTH            RAM address
//  ram_wdata  out  DATA_WIDTH            RAM write data
//  ram_rdata  in   DATA_WIDTH            RAM registered read data
// BEHAVIOUR
//  - Reset: ptr=0 (req 0 highest priority), state=ARB, beat_cnt=0, rsp_valid=0.
//    While rst=1: req_ready=0, ram_we=0.
//  - req_ready is combinational from req_valid/state; at most one bit set, and only if that req_valid=1.
//  - Ready never asserted without valid.
//  - Requesters must hold valid/we/addr/wdata stable until accepted.
//  - ram_addr/ram_wdata mux from the granted requester; ram_we = grant & req_we[g].
//  - With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
//  - Read accepted in cycle T -> rsp_valid[g]=1 in T+1 with rsp_rdata = mem[addr] (pre-write value).
//  - Writes produce no response.
//  - FSM ARB: grant first valid at or after ptr (wrapping NUM_REQ-1 -> 0).
//    On accept: ptr <= g+1 (mod NUM_REQ).
//    If req_lock[g]=1 and BURST_MAX>1: go to LOCK, owner<=g, beat_cnt<=1.
//  - FSM LOCK: only owner eligible.
//    Owner valid: grant; beat_cnt++.
//    Leave LOCK when req_lock[owner]=0 on an accepted beat, or beat_cnt reaches BURST_MAX.
//  - LOCK, owner valid=0: other requesters stay blocked.
//    Exit to ARB if req_lock[owner] drops while idle.
//  - On LOCK exit: ptr = owner+1; the owner loses priority (no starvation).
//  - Mixed read/write inside a burst is legal.
//  - Back-to-back accesses are full throughput: 1 access/cycle, no bubbles on grant change.
//  - rst mid-burst: state->ARB immediately; a pending rsp_valid is dropped (cleared).
// CONFIGURATION
//  BRAM_ARB_PERF_EN defined: adds outputs perf_grants[NUM_REQ][31:0] and perf_stall[NUM_REQ][31:0].
//   - perf_grants counts accepts; perf_stall counts valid&!ready cycles.
//   - Both saturating at 2^32-1 and cleared by rst.
//  Undefined: ports and counters absent; functionally identical otherwise.
// STRUCTURE
//  - Package bram_arb_pkg: arb_state_e {ARB, LOCK}; helper function next_ptr(); NUM_REQ bounds check.
//  - Sub-module rr_pick: combinational round-robin picker (valid vector + ptr -> one-hot grant + index).
//  - Reused by future arbiters.
// TESTING
//  1) Reset: rst=1 for 3 cycles with all req_valid=1 -> req_ready=0, ram_we=0, rsp_valid=0 throughout.
//  2) Fairness: all 4 valid reads, no lock, 8 cycles -> grants 0,1,2,3,0,1,2,3; each rsp_valid 1 cycle later.
//  3) Read-first: req1 writes 0xDEADBEEF to addr 5, then req2 reads 5 next cycle -> rsp_valid[2], rdata=0xDEADBEEF.
//     Simultaneous-cycle read returns old value.
//  4) Burst cap: BURST_MAX=4, req0 lock held, 4 valid -> req0 granted 4 beats, then req1.
//     req0 regains only after req1..3.
//  5) Lock hold while idle: req3 locks, drops valid 2 cycles with lock high -> no other grants.
//     Lock drop -> ARB next cycle.
//  6) Reset mid-burst: rst during LOCK after a read accept -> rsp_valid=0 next cycle; ptr=0 after reset.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM round-robin arbiter.
// Holds the arbiter state encoding, the requester-count bounds and the pointer-advance helper.
package bram_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 16;

    function automatic bit num_req_ok(input int n);
        return (n >= NUM_REQ_MIN) && (n <= NUM_REQ_MAX);
    endfunction

    // Round-robin successor of cur among n requesters.
    function automatic int next_ptr(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Grants the first set bit of valid at or after ptr, wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    idx
);

    int             cand;
    logic [IDXW-1:0] cand_idx;
    logic           found;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDXW'(cand);
            if (!found && valid[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port read-first block RAM among NUM_REQ requesters.
// Optional BRAM_ARB_PERF_EN adds per-requester saturating grant/stall counters.
//
// state | meaning
// ARB   | round-robin among all valid requesters starting at ptr
// LOCK  | only owner may be granted; burst of up to BURST_MAX beats
module bram_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ-1:0]                  req_lock,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                ram_we,
    output logic [ADDR_WIDTH-1:0]               ram_addr,
    output logic [DATA_WIDTH-1:0]               ram_wdata,
    input  logic [DATA_WIDTH-1:0]               ram_rdata
`ifdef BRAM_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][31:0]            perf_grants,
    output logic [NUM_REQ-1:0][31:0]            perf_stall
`endif
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int BCW  = $clog2(BURST_MAX + 1);

    localparam logic [0:0] ST_ARB  = ARB;
    localparam logic [0:0] ST_LOCK = LOCK;

    if (!num_req_ok(NUM_REQ) || BURST_MAX < 1 || BURST_MAX > 256) begin : g_bad_params
        $error("bram_rr_arbiter: NUM_REQ must be 2..16 and BURST_MAX 1..256");
    end

    logic [0:0]         state;
    logic [IDXW-1:0]    ptr;
    logic [IDXW-1:0]    owner;
    logic [BCW-1:0]     beat_cnt;
    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDXW-1:0]    grant_idx;
    logic               accept;
    logic               last_beat;
    logic               lock_exit;

    assign owner_mask = NUM_REQ'(1) << owner;
    assign eligible   = (state == ST_LOCK) ? (req_valid & owner_mask) : req_valid;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (eligible),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    always_comb begin
        req_ready = rst ? '0 : grant;
        accept    = |req_ready;
        ram_we    = accept & req_we[grant_idx];
        ram_addr  = accept ? req_addr[grant_idx]  : '0;
        ram_wdata = accept ? req_wdata[grant_idx] : '0;
    end

    assign rsp_rdata = ram_rdata;
    assign last_beat = (int'(beat_cnt) + 1) >= BURST_MAX;
    // Idle owner releases by dropping lock; an active owner also releases at the burst cap.
    assign lock_exit = !req_lock[owner] || (accept && last_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ARB;
            ptr       <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= req_ready & ~req_we;
            if (state == ST_ARB) begin
                if (accept) begin
                    ptr <= IDXW'(next_ptr(int'(grant_idx), NUM_REQ));
                    if (req_lock[grant_idx] && BURST_MAX > 1) begin
                        state    <= ST_LOCK;
                        owner    <= grant_idx;
                        beat_cnt <= BCW'(1);
                    end
                end
            end else begin
                if (lock_exit) begin
                    state    <= ST_ARB;
                    ptr      <= IDXW'(next_ptr(int'(owner), NUM_REQ));
                    beat_cnt <= '0;
                end else if (accept) begin
                    beat_cnt <= beat_cnt + BCW'(1);
                end
            end
        end
    end

`ifdef BRAM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && perf_grants[i] != 32'hFFFF_FFFF)
                    perf_grants[i] <= perf_grants[i] + 32'd1;
                if (req_valid[i] && !req_ready[i] && perf_stall[i] != 32'hFFFF_FFFF)
                    perf_stall[i] <= perf_stall[i] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Self-checking bench for bram_rr_arbiter with a read-first block RAM model attached.
// Table-driven vectors for arbitration/burst behaviour plus hand sequences for RAM data and reset.
module tb_bram_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BM = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_we;
    logic [N-1:0]         req_lock;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_wdata;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic [DW-1:0]        ram_rdata;
`ifdef BRAM_ARB_PERF_EN
    logic [N-1:0][31:0]   perf_grants;
    logic [N-1:0][31:0]   perf_stall;
`endif

    always #5 clk = ~clk;

    bram_rr_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef BRAM_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    // Read-first single-port RAM
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        ram_rdata <= ram[ram_addr];
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    typedef struct {
        logic [3:0] valid;
        logic [3:0] we;
        logic [3:0] lock;
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
    } vec_t;

    vec_t          vecs [24];
    logic [DW-1:0] exp_mem [256];
    logic [DW-1:0] pend_rdata;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++)
            if (oh[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic check_outputs(input string tag, input logic [3:0] exp_ready,
                                 input logic [3:0] exp_rsp);
        logic [1:0]    g;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        g         = oh2idx(exp_ready);
        exp_we    = (exp_ready != 4'b0) && req_we[g];
        exp_addr  = (exp_ready != 4'b0) ? req_addr[g]  : '0;
        exp_wdata = (exp_ready != 4'b0) ? req_wdata[g] : '0;
        check({tag, " ready"},     32'(req_ready), 32'(exp_ready));
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(exp_rsp));
        check({tag, " ram_we"},    32'(ram_we),    32'(exp_we));
        check({tag, " ram_addr"},  32'(ram_addr),  32'(exp_addr));
        check({tag, " ram_wdata"}, ram_wdata,      exp_wdata);
        if (exp_rsp != 4'b0) check({tag, " rsp_rdata"}, rsp_rdata, pend_rdata);
        if (exp_ready != 4'b0) begin
            if (exp_we) exp_mem[exp_addr] = exp_wdata;
            else        pend_rdata = exp_mem[exp_addr];
        end
    endtask

    task automatic cycle(input string tag, input logic [3:0] v, input logic [3:0] w,
                         input logic [3:0] l, input logic [3:0] exp_ready,
                         input logic [3:0] exp_rsp);
        req_valid = v;
        req_we    = w;
        req_lock  = l;
        @(negedge clk);
        check_outputs(tag, exp_ready, exp_rsp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h5500_0000 | 32'(i);
            exp_mem[i] = 32'h5500_0000 | 32'(i);
        end
        pend_rdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i]  = AW'(8'h10 + i);
            req_wdata[i] = 32'hA000_0000 + 32'(i);
        end

        //          valid    we       lock     ready    rsp
        vecs[0]  = '{4'hF,   4'h0,    4'h0,    4'b0001, 4'b0000};
        vecs[1]  = '{4'hF,   4'h0,    4'h0,    4'b0010, 4'b0001};
        vecs[2]  = '{4'hF,   4'h0,    4'h0,    4'b0100, 4'b0010};
        vecs[3]  = '{4'hF,   4'h0,    4'h0,    4'b1000, 4'b0100};
        vecs[4]  = '{4'hF,   4'h0,    4'h0,    4'b0001, 4'b1000};
        vecs[5]  = '{4'hF,   4'h0,    4'h0,    4'b0010, 4'b0001};
        vecs[6]  = '{4'hF,   4'h0,    4'h0,    4'b0100, 4'b0010};
        vecs[7]  = '{4'hF,   4'h0,    4'h0,    4'b1000, 4'b0100};
        vecs[8]  = '{4'hF,   4'h0,    4'h1,    4'b0001, 4'b1000};
        vecs[9]  = '{4'hF,   4'h0,    4'h1,    4'b0001, 4'b0001};
        vecs[10] = '{4'hF,   4'h0,    4'h1,    4'b0001, 4'b0001};
        vecs[11] = '{4'hF,   4'h0,    4'h1,    4'b0001, 4'b0001};
        vecs[12] = '{4'hF,   4'h0,    4'h1,    4'b0010, 4'b0001};
        vecs[13] = '{4'hF,   4'h0,    4'h1,    4'b0100, 4'b0010};
        vecs[14] = '{4'hF,   4'h0,    4'h1,    4'b1000, 4'b0100};
        vecs[15] = '{4'hF,   4'h0,    4'h1,    4'b0001, 4'b1000};
        vecs[16] = '{4'h0,   4'h0,    4'h0,    4'b0000, 4'b0001};
        vecs[17] = '{4'h8,   4'h0,    4'h8,    4'b1000, 4'b0000};
        vecs[18] = '{4'h7,   4'h0,    4'h8,    4'b0000, 4'b1000};
        vecs[19] = '{4'h7,   4'h0,    4'h8,    4'b0000, 4'b0000};
        vecs[20] = '{4'h7,   4'h0,    4'h0,    4'b0000, 4'b0000};
        vecs[21] = '{4'h7,   4'h0,    4'h0,    4'b0001, 4'b0000};
        vecs[22] = '{4'h6,   4'h2,    4'h0,    4'b0010, 4'b0001};
        vecs[23] = '{4'h0,   4'h0,    4'h0,    4'b0000, 4'b0000};

        // Reset held with every requester asking to write
        rst       = 1'b1;
        req_valid = 4'hF;
        req_we    = 4'hF;
        req_lock  = 4'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_outputs($sformatf("reset%0d", c), 4'b0000, 4'b0000);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        for (int k = 0; k < 24; k++)
            cycle($sformatf("row%0d", k), vecs[k].valid, vecs[k].we, vecs[k].lock,
                  vecs[k].exp_ready, vecs[k].exp_rsp);

        // Write then read the same address; later write must not disturb the earlier read
        req_addr[1] = 8'h05; req_wdata[1] = 32'hDEAD_BEEF;
        req_addr[2] = 8'h05;
        req_addr[3] = 8'h05; req_wdata[3] = 32'hCAFE_F00D;
        cycle("rf_wr1", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
        cycle("rf_rd2", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        cycle("rf_wr3", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0100);
        cycle("rf_rd2b", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        cycle("rf_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100);

        // Reset in the middle of a locked burst
        req_addr[0] = 8'h10;
        cycle("mrst_acc", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        rst = 1'b1;
        cycle("mrst_hold", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        rst = 1'b0;
        cycle("mrst_ptr0", 4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        cycle("mrst_ptr1", 4'b0110, 4'b0000, 4'b0000, 4'b0010, 4'b0001);
        cycle("mrst_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
